spi_axi_arb: RTL and testbench
==============================

# spi_axi_arb

Two-requester AXI4-Lite master arbiter for the SPI-to-AXI bridge. It accepts single-cycle word read/write strobes from two register-access front ends, such as the SPI command decoder and a second debug port. It serialises them round-robin onto one AXI4-Lite master interface and returns read data, completion and error status to each requester. It sits between the protocol decoders and the AXI interconnect.

## Interface
Parameters:
- C_ADDR_WIDTH, 15: requester word-address width; AXI byte address is {addr, 2'b00}.
- C_TIMEOUT, 255: cycles allowed per AXI transaction (used only with timeout compiled in).

Ports (N = 0, 1):
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_wr_en  in  1  one-cycle write strobe.
- reqN_wr_addr  in  C_ADDR_WIDTH  write word address, valid with strobe.
- reqN_wr_data  in  32  write data, valid with strobe.
- reqN_rd_en  in  1  one-cycle read strobe.
- reqN_rd_addr  in  C_ADDR_WIDTH  read word address, valid with strobe.
- reqN_rd_data  out  32  last read result, held until next read completes.
- reqN_busy  out  1  command pending or in flight for requester N.
- reqN_done  out  1  one-cycle completion pulse.
- reqN_err  out  1  qualified by done; SLVERR/DECERR response or timeout.
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready  AXI4-Lite write channels; addresses are C_ADDR_WIDTH+2 bits, wstrb is always 4'hF.
- m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  AXI4-Lite read channels.

## Operation
- Each requester has a one-deep pending slot holding op, address and data.
- A strobe is captured when reqN_busy=0. A strobe while busy=1 is silently dropped.
- If wr_en and rd_en are asserted in the same cycle, the write is captured and the read is dropped.
- busy rises the cycle after capture. It falls in the same cycle done is asserted.
- Arbitration uses a last-grant pointer, reset value 1, so requester 0 wins the first tie.
  - If both slots are pending in IDLE, the requester not last granted wins.
  - A single pending requester is always granted.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
  - IDLE -> WR_REQ or RD_REQ on grant. Address and data are latched from the granted slot.
  - WR_REQ: awvalid and wvalid are asserted together. Each is deasserted independently on its own ready. Go to WR_RESP when both handshakes are done, in either order or the same cycle.
  - WR_RESP: bready=1. On bvalid, latch bresp and go to DONE.
  - RD_REQ: arvalid=1 until arready. Then go to RD_RESP.
  - RD_RESP: rready=1. On rvalid, latch rdata and rresp and go to DONE.
  - DONE: pulse reqN_done for the granted requester. reqN_err = (resp != 2'b00). Update reqN_rd_data for reads only. Clear the slot, update the pointer, go to IDLE.
- A requester may strobe again in the cycle after its done pulse.
- Valid signals never drop before their ready, except on a timeout abort.

## Timing
- Reset values:
  - All AXI valid/ready outputs 0; addresses, wdata 0.
  - reqN_rd_data 0; busy, done, err 0; all slots empty.
  - State IDLE; pointer 1.
- Reset asserted mid-transaction clears everything immediately, asynchronously. No transaction is resumed.
- Write, zero-wait slave, strobe in cycle T:
  - busy in T+1, grant in T+1.
  - aw/wvalid in T+2, bvalid earliest T+3.
  - done in T+4.
- Read, zero-wait slave: arvalid T+2, rvalid earliest T+3, done T+4, rd_data valid from T+4.
- Back-to-back, both pending: the second grant is in the cycle after DONE, so there is one IDLE cycle between transactions.
- Strobe to the idle requester during another's transaction is captured normally and waits.

## Configuration
- SPI_AXI_ARB_TIMEOUT_EN defined: an 8+ bit counter clears on leaving IDLE and increments each cycle in the REQ/RESP states.
  - When the count reaches C_TIMEOUT, all valids and readies drop and the FSM goes to DONE with err=1.
  - On a read abort, rd_data is set to 32'hDEADBEEF.
- Not defined: no counter; the FSM waits indefinitely; err comes only from bresp/rresp.

## Test plan
- Req0 writes addr 0x0012, data 0xA5A5_1234, zero-wait slave -> awaddr=0x00048, wdata matches, wstrb=F, done0 at T+4, err0=0.
- Req1 reads addr 0x7FFF; slave answers rdata 0xCAFEF00D, rresp OKAY after 3 wait cycles -> araddr=0x1FFFC, rd_data1=0xCAFEF00D, done1 one cycle after the R handshake.
- Both requesters strobe in the same cycle, repeated 4 times -> grants alternate 0,1,0,1. A strobe while busy is dropped and produces exactly 4 done pulses per requester in total.
- Slave asserts wready 2 cycles before awready; bresp=SLVERR -> wvalid drops first, a single B handshake follows, err0=1 with done0.
- rst_n asserted while in RD_RESP -> arvalid/rready/busy go to 0 immediately; after release, a new read completes normally.
- With SPI_AXI_ARB_TIMEOUT_EN and C_TIMEOUT=16, the slave never asserts arready -> arvalid drops after 16 cycles, done0=1, err0=1, rd_data0=0xDEADBEEF.

Source files
------------

// File: rtl/spi_axi_arb.sv
// Two-requester round-robin arbiter driving one AXI4-Lite master port.
// Optional per-transaction timeout abort: define SPI_AXI_ARB_TIMEOUT_EN.
module spi_axi_arb #(
  parameter int C_ADDR_WIDTH = 15,
  parameter int C_TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_wr_en,
  input  logic [C_ADDR_WIDTH-1:0] req0_wr_addr,
  input  logic [31:0]             req0_wr_data,
  input  logic                    req0_rd_en,
  input  logic [C_ADDR_WIDTH-1:0] req0_rd_addr,
  output logic [31:0]             req0_rd_data,
  output logic                    req0_busy,
  output logic                    req0_done,
  output logic                    req0_err,
  input  logic                    req1_wr_en,
  input  logic [C_ADDR_WIDTH-1:0] req1_wr_addr,
  input  logic [31:0]             req1_wr_data,
  input  logic                    req1_rd_en,
  input  logic [C_ADDR_WIDTH-1:0] req1_rd_addr,
  output logic [31:0]             req1_rd_data,
  output logic                    req1_busy,
  output logic                    req1_done,
  output logic                    req1_err,
  output logic [C_ADDR_WIDTH+1:0] m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [C_ADDR_WIDTH+1:0] m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [31:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [2:0]              dbg_state
);

  localparam int AW = C_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      wr_en, rd_en;
  logic [AW-1:0]   wr_addr [2];
  logic [AW-1:0]   rd_addr [2];
  logic [31:0]     wr_data [2];
  logic [1:0]      pend_q, op_wr_q, fin, busy;
  logic [AW-1:0]   slot_addr_q [2];
  logic [31:0]     slot_data_q [2];
  logic [31:0]     rd_data_q [2];
  logic            cur_q, last_q, gnt_any, gnt_sel;
  logic            aw_pend_q, w_pend_q, aw_ok, w_ok;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            err_q;
  logic            tmo;

  assign wr_en      = {req1_wr_en, req0_wr_en};
  assign rd_en      = {req1_rd_en, req0_rd_en};
  assign wr_addr[0] = req0_wr_addr;
  assign wr_addr[1] = req1_wr_addr;
  assign rd_addr[0] = req0_rd_addr;
  assign rd_addr[1] = req1_rd_addr;
  assign wr_data[0] = req0_wr_data;
  assign wr_data[1] = req1_wr_data;

  // A slot stops reporting busy in its DONE cycle so the requester can re-strobe at once.
  assign fin  = (state_q == DONE) ? (cur_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy = pend_q & ~fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      op_wr_q <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!busy[i] && wr_en[i]) begin
          pend_q[i]      <= 1'b1;
          op_wr_q[i]     <= 1'b1;
          slot_addr_q[i] <= wr_addr[i];
          slot_data_q[i] <= wr_data[i];
        end else if (!busy[i] && rd_en[i]) begin
          pend_q[i]      <= 1'b1;
          op_wr_q[i]     <= 1'b0;
          slot_addr_q[i] <= rd_addr[i];
        end else if (fin[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  assign gnt_any = |pend_q;
  assign gnt_sel = (&pend_q) ? ~last_q : pend_q[1];

`ifdef SPI_AXI_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(C_TIMEOUT + 1) > 8) ? $clog2(C_TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (state_q == IDLE)  cnt_q <= '0;
    else if (state_q != DONE)  cnt_q <= cnt_q + CW'(1);
  end

  // Abort on the cycle whose increment would reach C_TIMEOUT.
  assign tmo = (state_q != IDLE) && (state_q != DONE) &&
               (cnt_q == CW'(C_TIMEOUT - 1));
`else
  assign tmo = (C_TIMEOUT < 0);
`endif

  // Handshake rule: a valid stays high until the matching ready is seen in the
  // same cycle; only a timeout abort may drop it early. Readies are held only
  // in the state that expects the response.
  assign aw_ok = !aw_pend_q || m_axi_awready;
  assign w_ok  = !w_pend_q  || m_axi_wready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = op_wr_q[gnt_sel] ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_ok && w_ok) state_d = WR_RESP;
               else if (tmo)      state_d = DONE;
      WR_RESP: if (m_axi_bvalid || tmo) state_d = DONE;
      RD_REQ:  if (m_axi_arready) state_d = RD_RESP;
               else if (tmo)      state_d = DONE;
      RD_RESP: if (m_axi_rvalid || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_q        <= 1'b0;
      last_q       <= 1'b1;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rd_data_q[0] <= '0;
      rd_data_q[1] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            cur_q     <= gnt_sel;
            addr_q    <= slot_addr_q[gnt_sel];
            wdata_q   <= slot_data_q[gnt_sel];
            aw_pend_q <= op_wr_q[gnt_sel];
            w_pend_q  <= op_wr_q[gnt_sel];
            err_q     <= 1'b0;
          end
        end
        WR_REQ: begin
          if (state_d == DONE) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            if (m_axi_awready) aw_pend_q <= 1'b0;
            if (m_axi_wready)  w_pend_q  <= 1'b0;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) err_q <= (m_axi_bresp != 2'b00);
          else if (tmo)     err_q <= 1'b1;
        end
        RD_REQ: begin
          if (state_d == DONE) begin
            err_q            <= 1'b1;
            rd_data_q[cur_q] <= 32'hDEADBEEF;
          end
        end
        RD_RESP: begin
          if (m_axi_rvalid) begin
            err_q            <= (m_axi_rresp != 2'b00);
            rd_data_q[cur_q] <= m_axi_rdata;
          end else if (tmo) begin
            err_q            <= 1'b1;
            rd_data_q[cur_q] <= 32'hDEADBEEF;
          end
        end
        DONE:    last_q <= cur_q;
        default: ;
      endcase
    end
  end

  assign m_axi_awaddr  = {addr_q, 2'b00};
  assign m_axi_araddr  = {addr_q, 2'b00};
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awvalid = aw_pend_q;
  assign m_axi_wvalid  = w_pend_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_arvalid = (state_q == RD_REQ);
  assign m_axi_rready  = (state_q == RD_RESP);

  assign req0_rd_data = rd_data_q[0];
  assign req1_rd_data = rd_data_q[1];
  assign req0_busy    = busy[0];
  assign req1_busy    = busy[1];
  assign req0_done    = fin[0];
  assign req1_done    = fin[1];
  assign req0_err     = fin[0] & err_q;
  assign req1_err     = fin[1] & err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_axi_arb.sv
// Scoreboard bench for spi_axi_arb: directed requester traffic against a
// configurable-latency AXI4-Lite slave model.
module tb_spi_axi_arb;

  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req0_wr_en, req0_rd_en, req1_wr_en, req1_rd_en;
  logic [AW-1:0] req0_wr_addr, req0_rd_addr, req1_wr_addr, req1_rd_addr;
  logic [31:0]   req0_wr_data, req1_wr_data, req0_rd_data, req1_rd_data;
  logic          req0_busy, req0_done, req0_err, req1_busy, req1_done, req1_err;
  logic [AW+1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [2:0]    dbg_state;

  spi_axi_arb #(.C_ADDR_WIDTH(AW), .C_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_wr_en(req0_wr_en), .req0_wr_addr(req0_wr_addr), .req0_wr_data(req0_wr_data),
    .req0_rd_en(req0_rd_en), .req0_rd_addr(req0_rd_addr), .req0_rd_data(req0_rd_data),
    .req0_busy(req0_busy), .req0_done(req0_done), .req0_err(req0_err),
    .req1_wr_en(req1_wr_en), .req1_wr_addr(req1_wr_addr), .req1_wr_data(req1_wr_data),
    .req1_rd_en(req1_rd_en), .req1_rd_addr(req1_rd_addr), .req1_rd_data(req1_rd_data),
    .req1_busy(req1_busy), .req1_done(req1_done), .req1_err(req1_err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .dbg_state(dbg_state)
  );

  // ---------------- AXI4-Lite slave model ----------------
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
  bit          ar_never = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  int          aw_cnt, w_cnt, ar_cnt, r_cnt;
  bit          aw_got, w_got, r_pend;
  int          b_hs = 0;

  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign arready = arvalid && !ar_never && (ar_cnt >= ar_wait);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready) w_got <= 1'b1;
      if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        bvalid <= 1'b1;
        bresp  <= b_resp_cfg;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_hs   <= b_hs + 1;
      end
      if (arvalid && arready) begin
        if (r_wait == 0) begin
          rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg;
        end else begin
          r_pend <= 1'b1; r_cnt <= 1;
        end
      end
      if (r_pend) begin
        if (r_cnt >= r_wait) begin
          rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg; r_pend <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        err;
    bit          chk_rd;
    logic [31:0] rd;
    int          cyc;
  } done_t;

  logic [AW+1:0] exp_aw_q[$];
  logic [AW+1:0] exp_ar_q[$];
  logic [31:0]   exp_w_q[$];
  done_t         exp_d0_q[$];
  done_t         exp_d1_q[$];
  int            n_checks = 0, n_fail = 0;
  int            n_done[2] = '{0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with no expectation or bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [AW+1:0] byte_addr(input logic [AW-1:0] a);
    return {a, 2'b00};
  endfunction

  task automatic exp_done(input int idx, input logic err, input bit chk, input logic [31:0] rd, input int c);
    done_t e;
    e.err = err; e.chk_rd = chk; e.rd = rd; e.cyc = c;
    if (idx == 0) exp_d0_q.push_back(e);
    else          exp_d1_q.push_back(e);
  endtask

  task automatic mon_done(input int idx, input logic err, input logic [31:0] rd, input logic bsy);
    done_t e;
    bit    have = 1'b0;
    n_done[idx]++;
    if (idx == 0 && exp_d0_q.size() > 0) begin e = exp_d0_q.pop_front(); have = 1'b1; end
    if (idx == 1 && exp_d1_q.size() > 0) begin e = exp_d1_q.pop_front(); have = 1'b1; end
    if (!have) begin
      fail_now($sformatf("done%0d_unexpected", idx));
    end else begin
      check($sformatf("done%0d_err", idx), err, e.err);
      check($sformatf("done%0d_cycle", idx), cyc, e.cyc);
      check($sformatf("busy%0d_at_done", idx), bsy, 1'b0);
      if (e.chk_rd) check($sformatf("rd_data%0d", idx), rd, e.rd);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (awvalid && awready) begin
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else check("awaddr", awaddr, exp_aw_q.pop_front());
      end
      if (wvalid && wready) begin
        if (exp_w_q.size() == 0) fail_now("w_unexpected");
        else begin
          check("wdata", wdata, exp_w_q.pop_front());
          check("wstrb", wstrb, 4'hF);
        end
      end
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) fail_now("ar_unexpected");
        else check("araddr", araddr, exp_ar_q.pop_front());
      end
      if (req0_done) mon_done(0, req0_err, req0_rd_data, req0_busy);
      if (req1_done) mon_done(1, req1_err, req1_rd_data, req1_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    req0_wr_en = 1'b0; req0_rd_en = 1'b0;
    req1_wr_en = 1'b0; req1_rd_en = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((req0_busy || req1_busy || dbg_state != 3'd0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) fail_now(name);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int T, d0, d1, b0, n;

  initial begin
    clear_strobes();
    req0_wr_addr = '0; req0_rd_addr = '0; req0_wr_data = '0;
    req1_wr_addr = '0; req1_rd_addr = '0; req1_wr_data = '0;
    rst_n = 1'b0;
    repeat (3) tick();

    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("rst_addr", {awaddr, araddr}, '0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_rd_data", {req0_rd_data, req1_rd_data}, 64'h0);
    check("rst_status", {req0_busy, req1_busy, req0_done, req1_done, req0_err, req1_err}, 6'b0);
    check("rst_state", dbg_state, 3'd0);

    @(negedge clk) rst_n = 1'b1;
    tick();

    // Single write from req0, zero-wait slave
    req0_wr_en = 1'b1; req0_wr_addr = 15'h0012; req0_wr_data = 32'hA5A5_1234;
    T = cyc;
    exp_aw_q.push_back(17'h00048);
    exp_w_q.push_back(32'hA5A5_1234);
    exp_done(0, 1'b0, 1'b0, 32'h0, T + 4);
    tick(); clear_strobes();
    check("busy0_after_strobe", req0_busy, 1'b1);
    wait_idle("idle_t1");

    // Simultaneous write and read strobe: only the write is taken
    req0_wr_en = 1'b1; req0_wr_addr = 15'h0021; req0_wr_data = 32'h0000_BEEF;
    req0_rd_en = 1'b1; req0_rd_addr = 15'h0022;
    T = cyc;
    exp_aw_q.push_back(byte_addr(15'h0021));
    exp_w_q.push_back(32'h0000_BEEF);
    exp_done(0, 1'b0, 1'b0, 32'h0, T + 4);
    tick(); clear_strobes();
    wait_idle("idle_wr_rd");

    // Tie with req0 last granted: req1 goes first
    req0_wr_en = 1'b1; req0_wr_addr = 15'h0030; req0_wr_data = 32'h3030_3030;
    req1_wr_en = 1'b1; req1_wr_addr = 15'h0031; req1_wr_data = 32'h3131_3131;
    T = cyc;
    exp_aw_q.push_back(byte_addr(15'h0031)); exp_w_q.push_back(32'h3131_3131);
    exp_aw_q.push_back(byte_addr(15'h0030)); exp_w_q.push_back(32'h3030_3030);
    exp_done(1, 1'b0, 1'b0, 32'h0, T + 4);
    exp_done(0, 1'b0, 1'b0, 32'h0, T + 8);
    tick(); clear_strobes();
    wait_idle("idle_tie");

    // req1 read at top address, 3 wait cycles before R
    r_wait = 3; r_data_cfg = 32'hCAFE_F00D;
    req1_rd_en = 1'b1; req1_rd_addr = 15'h7FFF;
    T = cyc;
    exp_ar_q.push_back(17'h1FFFC);
    exp_done(1, 1'b0, 1'b1, 32'hCAFE_F00D, T + 7);
    tick(); clear_strobes();
    wait_idle("idle_t2");
    check("rd_data1_held", req1_rd_data, 32'hCAFE_F00D);

    // Four rounds of simultaneous strobes, extra strobes while busy are dropped
    r_wait = 0;
    d0 = n_done[0]; d1 = n_done[1];
    for (int i = 0; i < 4; i++) begin
      r_data_cfg = 32'h0BAD_0000 + i;
      req0_wr_en = 1'b1; req0_wr_addr = 15'h0100 + 15'(i); req0_wr_data = 32'h1111_0000 + i;
      req1_rd_en = 1'b1; req1_rd_addr = 15'h0200 + 15'(i);
      T = cyc;
      exp_aw_q.push_back(byte_addr(15'h0100 + 15'(i)));
      exp_w_q.push_back(32'h1111_0000 + i);
      exp_ar_q.push_back(byte_addr(15'h0200 + 15'(i)));
      exp_done(0, 1'b0, 1'b0, 32'h0, T + 4);
      exp_done(1, 1'b0, 1'b1, 32'h0BAD_0000 + i, T + 8);
      tick(); clear_strobes();
      tick();
      req0_rd_en = 1'b1; req0_rd_addr = 15'h03FF;
      req1_wr_en = 1'b1; req1_wr_addr = 15'h03FE; req1_wr_data = 32'hFFFF_FFFF;
      tick(); clear_strobes();
      wait_idle("idle_rr");
    end
    check("rr_done0_count", n_done[0] - d0, 4);
    check("rr_done1_count", n_done[1] - d1, 4);

    // W accepted 2 cycles before AW, SLVERR response
    aw_wait = 2; b_resp_cfg = 2'b10; b0 = b_hs;
    req0_wr_en = 1'b1; req0_wr_addr = 15'h0040; req0_wr_data = 32'hDEAD_0040;
    T = cyc;
    exp_aw_q.push_back(byte_addr(15'h0040));
    exp_w_q.push_back(32'hDEAD_0040);
    exp_done(0, 1'b1, 1'b0, 32'h0, T + 6);
    tick(); clear_strobes();
    at_cycle(T + 2);
    check("slverr_both_valid", {awvalid, wvalid}, 2'b11);
    at_cycle(T + 3);
    check("slverr_wvalid_first", {awvalid, wvalid}, 2'b10);
    wait_idle("idle_slverr");
    check("slverr_b_count", b_hs - b0, 1);
    aw_wait = 0; b_resp_cfg = 2'b00;

    // Reset while waiting in RD_RESP
    r_wait = 10;
    req0_rd_en = 1'b1; req0_rd_addr = 15'h0055;
    exp_ar_q.push_back(byte_addr(15'h0055));
    tick(); clear_strobes();
    n = 0;
    while (!rready && n < 20) begin tick(); n++; end
    if (n >= 20) fail_now("rready_wait");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {arvalid, rready, req0_busy, dbg_state}, 6'b0);
    check("rst_mid_rd_data0", req0_rd_data, 32'h0);
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    r_wait = 0; r_data_cfg = 32'h1234_5678;
    req0_rd_en = 1'b1; req0_rd_addr = 15'h0066;
    T = cyc;
    exp_ar_q.push_back(byte_addr(15'h0066));
    exp_done(0, 1'b0, 1'b1, 32'h1234_5678, T + 4);
    tick(); clear_strobes();
    wait_idle("idle_after_rst");

`ifdef SPI_AXI_ARB_TIMEOUT_EN
    // AR never accepted: abort after 16 cycles
    ar_never = 1'b1;
    req0_rd_en = 1'b1; req0_rd_addr = 15'h0077;
    T = cyc;
    exp_done(0, 1'b1, 1'b1, 32'hDEAD_BEEF, T + 18);
    tick(); clear_strobes();
    n = 0;
    for (int k = 0; k < 30; k++) begin
      if (arvalid) n++;
      tick();
    end
    check("tmo_arvalid_cycles", n, 16);
    ar_never = 1'b0;
    wait_idle("idle_tmo");
`endif

    repeat (3) tick();
    check("aw_queue_empty", exp_aw_q.size(), 0);
    check("w_queue_empty", exp_w_q.size(), 0);
    check("ar_queue_empty", exp_ar_q.size(), 0);
    check("done0_queue_empty", exp_d0_q.size(), 0);
    check("done1_queue_empty", exp_d1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
